// File: rtl/audio_clk_reconfig_ctrl.sv
// Audio clock PLL sequencer: power-up, frequency changes, lock wait with timeout/retry,
// and audio-domain reset release once the new clock has been locked for a settle window.
module audio_clk_reconfig_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 256,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_freq,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic [1:0] pll_freq_sel,
    output logic       audio_rst,
    output logic [1:0] cur_freq,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int RST_W = $clog2(RST_CYCLES) + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int TMO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int RTY_W = $clog2(MAX_RETRIES) + 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_DONE = SET_W'(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    // ST_ACK is the one-cycle acknowledge of a request for the frequency already running.
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4,
        ST_ACK       = 3'd5
    } state_t;

    state_t             state_r, state_n;
    logic [RST_W-1:0]   rst_cnt_r, rst_cnt_n;
    logic [SET_W-1:0]   settle_r, settle_n;
    logic [TMO_W-1:0]   timer_r, timer_n;
    logic [RTY_W-1:0]   retry_r, retry_n, retry_inc_s;
    logic               lock_meta_r;
    logic               lock_s;
    logic [1:0]         freq_sel_n, cur_freq_n;
    logic               pll_rst_n, audio_rst_n, busy_n, req_ready_n, error_n, done_n;
    logic               accept_s;

    function automatic logic [RTY_W-1:0] sat_inc_rty(input logic [RTY_W-1:0] v);
        sat_inc_rty = (v == {RTY_W{1'b1}}) ? v : v + RTY_W'(1);
    endfunction

    function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
        sat_inc_tmo = (v == {TMO_W{1'b1}}) ? v : v + TMO_W'(1);
    endfunction

    assign accept_s    = req_valid & req_ready;
    assign retry_inc_s = sat_inc_rty(retry_r);

    // State, counters, lock synchroniser and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r      <= ST_PLL_RST;
            rst_cnt_r    <= '0;
            settle_r     <= '0;
            timer_r      <= '0;
            retry_r      <= '0;
            lock_meta_r  <= 1'b0;
            lock_s       <= 1'b0;
            pll_rst      <= 1'b1;
            audio_rst    <= 1'b1;
            pll_freq_sel <= 2'd0;
            cur_freq     <= 2'd0;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_r      <= state_n;
            rst_cnt_r    <= rst_cnt_n;
            settle_r     <= settle_n;
            timer_r      <= timer_n;
            retry_r      <= retry_n;
            lock_meta_r  <= pll_locked;
            lock_s       <= lock_meta_r;
            pll_rst      <= pll_rst_n;
            audio_rst    <= audio_rst_n;
            pll_freq_sel <= freq_sel_n;
            cur_freq     <= cur_freq_n;
            req_ready    <= req_ready_n;
            busy         <= busy_n;
            done         <= done_n;
            error        <= error_n;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_n    = state_r;
        rst_cnt_n  = rst_cnt_r;
        settle_n   = settle_r;
        timer_n    = timer_r;
        retry_n    = retry_r;
        freq_sel_n = pll_freq_sel;
        cur_freq_n = cur_freq;
        case (state_r)
            ST_PLL_RST: begin
                if (rst_cnt_r >= RST_LAST) begin
                    state_n   = ST_WAIT_LOCK;
                    rst_cnt_n = '0;
                    timer_n   = '0;
                end else begin
                    rst_cnt_n = rst_cnt_r + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    // The cycle that sees lock counts as the first settle cycle.
                    timer_n = '0;
                    if (SET_ONE >= SET_DONE) begin
                        state_n    = ST_RUN;
                        settle_n   = '0;
                        retry_n    = '0;
                        cur_freq_n = pll_freq_sel;
                    end else begin
                        state_n  = ST_SETTLE;
                        settle_n = SET_ONE;
                    end
                end else if (timer_r >= TMO_LAST) begin
                    timer_n = '0;
                    retry_n = retry_inc_s;
                    if (retry_inc_s <= RTY_MAX) begin
                        state_n   = ST_PLL_RST;
                        rst_cnt_n = '0;
                    end else begin
                        state_n = ST_FAIL;
                    end
                end else begin
                    timer_n = sat_inc_tmo(timer_r);
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_n  = ST_WAIT_LOCK;
                    timer_n  = '0;
                    settle_n = '0;
                end else if ((settle_r + SET_W'(1)) >= SET_DONE) begin
                    state_n    = ST_RUN;
                    settle_n   = '0;
                    retry_n    = '0;
                    cur_freq_n = pll_freq_sel;
                end else begin
                    settle_n = settle_r + SET_W'(1);
                end
            end
            ST_RUN: begin
                // A request outranks a simultaneous lock loss.
                if (accept_s) begin
                    if (req_freq != pll_freq_sel) begin
                        state_n    = ST_PLL_RST;
                        rst_cnt_n  = '0;
                        timer_n    = '0;
                        settle_n   = '0;
                        retry_n    = '0;
                        freq_sel_n = req_freq;
                    end else begin
                        state_n = ST_ACK;
                    end
                end else if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                    timer_n = '0;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_FAIL: begin
                if (accept_s) begin
                    state_n    = ST_PLL_RST;
                    rst_cnt_n  = '0;
                    timer_n    = '0;
                    settle_n   = '0;
                    retry_n    = '0;
                    freq_sel_n = req_freq;
                end else begin
                    state_n = ST_FAIL;
                end
            end
            ST_ACK: begin
                state_n = ST_RUN;
            end
            default: begin
                state_n   = ST_PLL_RST;
                rst_cnt_n = '0;
            end
        endcase
    end

    // Output values for the state being entered; registered above.
    always_comb begin
        pll_rst_n   = 1'b0;
        audio_rst_n = 1'b1;
        busy_n      = 1'b1;
        req_ready_n = 1'b0;
        error_n     = 1'b0;
        done_n      = 1'b0;
        case (state_n)
            ST_PLL_RST: begin
                pll_rst_n = 1'b1;
            end
            ST_WAIT_LOCK, ST_SETTLE: begin
                audio_rst_n = 1'b1;
            end
            ST_RUN: begin
                audio_rst_n = 1'b0;
                busy_n      = 1'b0;
                req_ready_n = 1'b1;
                done_n      = (state_r == ST_SETTLE) || (state_r == ST_WAIT_LOCK);
            end
            ST_ACK: begin
                audio_rst_n = 1'b0;
                done_n      = 1'b1;
            end
            ST_FAIL: begin
                busy_n      = 1'b0;
                req_ready_n = 1'b1;
                error_n     = 1'b1;
            end
            default: begin
                pll_rst_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_audio_clk_reconfig_ctrl.sv
// Directed bench for audio_clk_reconfig_ctrl with a behavioural PLL and a done/cur_freq scoreboard.
module tb_audio_clk_reconfig_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int SETTLE_CYCLES = 8;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int MAX_RETRIES   = 2;
    localparam int LOCK_DLY      = 5;
    localparam int SYNC_DLY      = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_freq = 2'd0;
    logic       pll_locked;
    logic       pll_rst;
    logic [1:0] pll_freq_sel;
    logic       audio_rst;
    logic [1:0] cur_freq;
    logic       busy;
    logic       done;
    logic       error;

    logic       pll_ok = 1'b1;
    logic       drop = 1'b0;
    logic       pll_model = 1'b0;
    int         lk_cnt = 0;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] exp_q[$];

    audio_clk_reconfig_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_freq    (req_freq),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .pll_freq_sel(pll_freq_sel),
        .audio_rst   (audio_rst),
        .cur_freq    (cur_freq),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 refclk = ~refclk;

    assign pll_locked = pll_model & ~drop;

    // Behavioural PLL: locks LOCK_DLY cycles after its reset is released.
    always @(posedge refclk) begin
        #2;
        if (pll_rst || !pll_ok) begin
            lk_cnt    = 0;
            pll_model = 1'b0;
        end else if (lk_cnt < LOCK_DLY) begin
            lk_cnt    = lk_cnt + 1;
            pll_model = (lk_cnt >= LOCK_DLY);
        end else begin
            pll_model = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every done pulse must match a queued expected cur_freq.
    always @(negedge refclk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                chk("cur_freq_at_done", 32'(cur_freq), 32'(exp_q.pop_front()));
                chk("audio_rst_at_done", 32'(audio_rst), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pll_rst_len(output int n);
        n = 0;
        while (pll_rst && n < 100) begin
            n++;
            @(negedge refclk);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge refclk);
            k++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_req(input logic [1:0] f);
        int k;
        k = 0;
        while (!req_ready && k < 200) begin
            @(negedge refclk);
            k++;
        end
        chk("req_ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_freq  = f;
        @(posedge refclk);
        #1;
        req_valid = 1'b0;
        @(negedge refclk);
    endtask

    initial begin
        int n;
        int k;
        logic seen_pll_rst;

        // 1. Boot
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        chk("rst_pll_rst", 32'(pll_rst), 32'd1);
        chk("rst_audio_rst", 32'(audio_rst), 32'd1);
        chk("rst_freq_sel", 32'(pll_freq_sel), 32'd0);
        chk("rst_cur_freq", 32'(cur_freq), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        exp_q.push_back(2'd0);
        rst = 1'b0;
        pll_rst_len(n);
        chk("boot_pll_rst_len", 32'(n), 32'(RST_CYCLES));
        k = 0;
        while (!pll_locked && k < 50) begin
            @(negedge refclk);
            k++;
        end
        chk("boot_lock_rise", 32'(pll_locked), 32'd1);
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (audio_rst && n < 100);
        chk("boot_audio_release", 32'(n), 32'(SYNC_DLY + SETTLE_CYCLES));
        chk("boot_done", 32'(done), 32'd1);
        chk("boot_busy", 32'(busy), 32'd0);
        chk("boot_req_ready", 32'(req_ready), 32'd1);

        // 2. Change to freq 2
        exp_q.push_back(2'd2);
        do_req(2'd2);
        chk("chg_freq_sel", 32'(pll_freq_sel), 32'd2);
        chk("chg_pll_rst", 32'(pll_rst), 32'd1);
        chk("chg_req_ready", 32'(req_ready), 32'd0);
        chk("chg_audio_rst", 32'(audio_rst), 32'd1);
        chk("chg_busy", 32'(busy), 32'd1);
        pll_rst_len(n);
        chk("chg_pll_rst_len", 32'(n), 32'(RST_CYCLES));
        wait_done("chg_done", 200);
        chk("chg_cur_freq", 32'(cur_freq), 32'd2);

        // 3. Same-frequency request
        exp_q.push_back(2'd2);
        do_req(2'd2);
        chk("same_done_t1", 32'(done), 32'd1);
        chk("same_ready_t1", 32'(req_ready), 32'd0);
        chk("same_busy_t1", 32'(busy), 32'd1);
        chk("same_pll_rst_t1", 32'(pll_rst), 32'd0);
        chk("same_audio_rst_t1", 32'(audio_rst), 32'd0);
        @(negedge refclk);
        chk("same_ready_t2", 32'(req_ready), 32'd1);
        chk("same_done_t2", 32'(done), 32'd0);
        chk("same_pll_rst_t2", 32'(pll_rst), 32'd0);
        chk("same_busy_t2", 32'(busy), 32'd0);

        // 5. One-cycle lock loss in RUN
        exp_q.push_back(2'd2);
        drop = 1'b1;
        @(negedge refclk);
        drop = 1'b0;
        chk("loss_audio_c1", 32'(audio_rst), 32'd0);
        @(negedge refclk);
        chk("loss_audio_c2", 32'(audio_rst), 32'd0);
        @(negedge refclk);
        chk("loss_audio_c3", 32'(audio_rst), 32'd1);
        n = 0;
        seen_pll_rst = 1'b0;
        while (audio_rst && n < 100) begin
            seen_pll_rst = seen_pll_rst | pll_rst;
            n++;
            @(negedge refclk);
        end
        chk("loss_audio_len", 32'(n), 32'(SETTLE_CYCLES));
        chk("loss_no_pll_rst", 32'(seen_pll_rst), 32'd0);
        chk("loss_cur_freq", 32'(cur_freq), 32'd2);

        // 4. PLL never locks: retries then FAIL
        pll_ok = 1'b0;
        do_req(2'd1);
        for (int i = 0; i < (MAX_RETRIES + 1) * (RST_CYCLES + LOCK_TIMEOUT); i++) begin
            chk($sformatf("retry_pll_rst_%0d", i), 32'(pll_rst),
                32'((i % (RST_CYCLES + LOCK_TIMEOUT)) < RST_CYCLES));
            @(negedge refclk);
        end
        chk("fail_error", 32'(error), 32'd1);
        chk("fail_req_ready", 32'(req_ready), 32'd1);
        chk("fail_pll_rst", 32'(pll_rst), 32'd0);
        chk("fail_audio_rst", 32'(audio_rst), 32'd1);
        chk("fail_busy", 32'(busy), 32'd0);
        @(negedge refclk);
        chk("fail_error_sticky", 32'(error), 32'd1);
        pll_ok = 1'b1;
        exp_q.push_back(2'd1);
        do_req(2'd1);
        chk("recover_error", 32'(error), 32'd0);
        chk("recover_pll_rst", 32'(pll_rst), 32'd1);
        chk("recover_busy", 32'(busy), 32'd1);
        chk("recover_ready", 32'(req_ready), 32'd0);
        wait_done("recover_done", 200);
        chk("recover_cur_freq", 32'(cur_freq), 32'd1);

        // 6. rst during WAIT_LOCK of a freq-3 change
        do_req(2'd3);
        chk("abort_freq_sel", 32'(pll_freq_sel), 32'd3);
        pll_rst_len(n);
        chk("abort_pll_rst_len", 32'(n), 32'(RST_CYCLES));
        @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        chk("abort_pll_rst", 32'(pll_rst), 32'd1);
        chk("abort_audio_rst", 32'(audio_rst), 32'd1);
        chk("abort_freq_sel0", 32'(pll_freq_sel), 32'd0);
        chk("abort_cur_freq", 32'(cur_freq), 32'd0);
        chk("abort_error", 32'(error), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        exp_q.push_back(2'd0);
        rst = 1'b0;
        pll_rst_len(n);
        chk("reboot_pll_rst_len", 32'(n), 32'(RST_CYCLES));
        wait_done("reboot_done", 200);
        chk("reboot_cur_freq", 32'(cur_freq), 32'd0);

        repeat (4) @(negedge refclk);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
